dmem_stall_ctrl: RTL and testbench
==================================

# dmem_stall_ctrl

Multi-cycle data-memory controller between the execute stage and the memory stage. Accepts one load/store per instruction from the EX/MEM boundary. Drives a variable-latency data memory and holds the pipeline with `memStall` until the access completes. Returns load data, flags unaligned, timed-out or memory-reported errors, and forwards halt dumps when the memory is idle.

## Interface
Parameters:
- `TIMEOUT`, default 15: maximum number of BUSY cycles to wait for `memDone` before declaring an error. Must be at least 1.
- `CNT_W`, default 4: width of the timeout counter. Must be at least clog2(TIMEOUT+1).

Ports:
- `clk`  in  1  Clock. All state changes on the rising edge.
- `rst`  in  1  Asynchronous, active-high reset.
- `memEn`  in  1  Current instruction accesses memory.
- `memWrt`  in  1  Access is a store. Ignored unless `memEn` is high.
- `addr`  in  16  Byte address (ALU result).
- `wrData`  in  16  Store data.
- `hazStall`  in  1  Hazard unit is holding this instruction. Blocks a new request.
- `halt`  in  1  Halt instruction is at this stage.
- `memDone`  in  1  Memory has completed the outstanding access.
- `memRdData`  in  16  Read data from memory. Valid only with `memDone`.
- `memErr`  in  1  Memory error. Sampled only with `memDone`.
- `memReq`  out  1  One-cycle request pulse to memory.
- `memReqWr`  out  1  Request is a write.
- `memAddr`  out  16  Latched request address.
- `memWrData`  out  16  Latched store data.
- `memDump`  out  1  One-cycle dump request to memory.
- `memStall`  out  1  Hold all upstream stages.
- `rdData`  out  16  Load result, registered.
- `rdValid`  out  1  `rdData` is valid this cycle.
- `err`  out  1  One-cycle error pulse.

## Operation
- The FSM has three states: IDLE, BUSY and DONE (2-bit encoding). Reset state is IDLE.
- A new request `start` = IDLE & `memEn` & !`hazStall`.
- IDLE, `start` with `addr[0]`=1 (unaligned): no memory request is issued. Go to DONE with an error pending, `rdData` unchanged.
- IDLE, `start` with an aligned address: latch `addr`, `wrData` and `memWrt` into `memAddr`, `memWrData` and `memReqWr`. Pulse `memReq` on the next cycle. Clear the counter. Go to BUSY.
- BUSY: the counter increments each cycle.
  - On `memDone`: for a load, capture `memRdData` into `rdData`. Record `memErr` as a pending error. Go to DONE.
  - If the counter reaches `TIMEOUT` without `memDone`: record a pending error and go to DONE; `rdData` is unchanged.
  - If `memDone` and the timeout occur in the same cycle, `memDone` wins. Data is captured, and the error pending is `memErr` only.
- DONE: `rdValid` is 1 for a load with no error. `err` is 1 if an error is pending. Return to IDLE unconditionally. The instruction advances this cycle, so no re-issue is allowed even though `memEn` is still high.
- `memStall` = (IDLE & `start`) | BUSY. It is 0 in DONE, and forced to 0 while `rst` is high.
- `memDump` pulses for one cycle when IDLE & `halt` & !`start`. If `halt` arrives while BUSY, the dump is deferred until the controller is back in IDLE. At most one dump is issued per `halt` assertion, using an edge-detect register.
- `memDone` arriving in IDLE or DONE (stray or late) is ignored.
- A store completes identically to a load but never asserts `rdValid`.

## Timing
- Reset values: state=IDLE, `memReq`=0, `memReqWr`=0, `memAddr`=0, `memWrData`=0, `memDump`=0, `rdData`=0, `rdValid`=0, `err`=0, counter=0, pending error=0.
- Reset mid-access abandons the request. The memory's later `memDone` is ignored.
- Memory latency L is the number of cycles from the `memReq` cycle to the `memDone` cycle, L>=0.
  - The `memReq` cycle is the first BUSY cycle.
  - Stall length is L+2 cycles: the start cycle plus L+1 BUSY cycles. DONE follows.
- Unaligned access stalls 1 cycle (the start cycle), followed by DONE.
- `rdData`, `rdValid` and `err` are registered outputs, valid in the DONE cycle.
- `memAddr`, `memWrData` and `memReqWr` are stable from the `memReq` cycle through DONE.
- Back-to-back accesses: DONE, then IDLE with the next instruction. The minimum spacing is one non-stalled cycle between requests.

## Test plan
- Aligned load, addr=0x0010, memory returns 0xBEEF with L=3: `memReq` pulses once, `memStall` is high 5 cycles, then DONE with `rdData`=0xBEEF, `rdValid`=1, `err`=0.
- Store, addr=0x0020, wrData=0x1234, L=0: `memReqWr`=1, `memWrData`=0x1234, stall 2 cycles, `rdValid`=0, `err`=0, no second `memReq`.
- Unaligned load, addr=0x0011: no `memReq`, stall 1 cycle, `err`=1 for one cycle, `rdData` unchanged.
- Timeout, TIMEOUT=15, `memDone` never asserted: `err` pulses after the 15th BUSY cycle, FSM returns to IDLE.
- Second case, `memDone` with `memErr`=1 in the same cycle the timeout is reached: `rdData` captured, `err`=1 for one cycle.
- `hazStall`=1 with `memEn`=1: no request and `memStall`=0. Release `hazStall` and the request starts the same cycle.
- Assert `rst` in the 2nd BUSY cycle: all outputs are 0 immediately. A late `memDone`=1 after reset leaves `rdValid`=0 and `err`=0.
- `halt` asserted while BUSY: `memDump`=0 until DONE has passed, then exactly one `memDump` pulse in IDLE.

Source files
------------

// File: rtl/dmem_stall_ctrl_if.sv
// Signal bundle between the EX/MEM boundary, the data memory and dmem_stall_ctrl.
interface dmem_stall_ctrl_if;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 16;

    // Pipeline side: request from the EX/MEM boundary
    logic              memEn;
    logic              memWrt;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wrData;
    logic              hazStall;
    logic              halt;

    // Memory side: completion from the data memory
    logic              memDone;
    logic [DATA_W-1:0] memRdData;
    logic              memErr;

    // Controller outputs toward the memory
    logic              memReq;
    logic              memReqWr;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWrData;
    logic              memDump;

    // Controller outputs toward the pipeline
    logic              memStall;
    logic [DATA_W-1:0] rdData;
    logic              rdValid;
    logic              err;

    // Controller view
    modport master (
        input  memEn, memWrt, addr, wrData, hazStall, halt,
        input  memDone, memRdData, memErr,
        output memReq, memReqWr, memAddr, memWrData, memDump,
        output memStall, rdData, rdValid, err
    );

    // Environment view (pipeline + memory)
    modport slave (
        output memEn, memWrt, addr, wrData, hazStall, halt,
        output memDone, memRdData, memErr,
        input  memReq, memReqWr, memAddr, memWrData, memDump,
        input  memStall, rdData, rdValid, err
    );
endinterface

// File: rtl/dmem_stall_ctrl.sv
// Multi-cycle data-memory controller: issues one access per instruction, stalls
// the pipeline until the memory answers or times out, and forwards halt dumps.
module dmem_stall_ctrl #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    dmem_stall_ctrl_if.master bus
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 16;
    // Counter value seen in the last BUSY cycle allowed before giving up
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;

    logic              r_memReq;
    logic              r_memReqWr;
    logic [ADDR_W-1:0] r_memAddr;
    logic [DATA_W-1:0] r_memWrData;
    logic [DATA_W-1:0] r_rdData;
    logic              r_rdValid;
    logic              r_err;
    logic              r_halt_served;

    logic              w_start;
    logic              w_unaligned;
    logic              w_timeout;
    logic              w_issue;
    logic              w_unal_err;
    logic              w_complete;
    logic              w_expire;
    logic              w_stall;
    logic              w_dump;

    assign w_start     = (r_state == S_IDLE) & bus.memEn & ~bus.hazStall;
    assign w_unaligned = bus.addr[0];
    assign w_timeout   = (r_cnt == CNT_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next = w_unaligned ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (bus.memDone || w_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                // Instruction advances this cycle; never re-issue on a held memEn
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Per-state control strobes; memDone outside BUSY is ignored by construction
    always_comb begin
        w_issue    = 1'b0;
        w_unal_err = 1'b0;
        w_complete = 1'b0;
        w_expire   = 1'b0;
        w_stall    = 1'b0;
        w_dump     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_issue    = w_start & ~w_unaligned;
                w_unal_err = w_start &  w_unaligned;
                w_stall    = w_start;
                w_dump     = bus.halt & ~w_start & ~r_halt_served;
            end
            S_BUSY: begin
                w_stall    = 1'b1;
                w_complete = bus.memDone;
                // memDone wins over a coincident timeout
                w_expire   = ~bus.memDone & w_timeout;
            end
            default: begin
            end
        endcase
        if (rst) begin
            w_stall = 1'b0;
            w_dump  = 1'b0;
        end
    end

    // BUSY-cycle counter, cleared when a request is launched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_issue) begin
            r_cnt <= '0;
        end else if (r_state == S_BUSY) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Request pulse and latched request fields, held stable through DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_memReq    <= 1'b0;
            r_memReqWr  <= 1'b0;
            r_memAddr   <= '0;
            r_memWrData <= '0;
        end else begin
            r_memReq <= w_issue;
            if (w_issue) begin
                r_memReqWr  <= bus.memWrt;
                r_memAddr   <= bus.addr;
                r_memWrData <= bus.wrData;
            end
        end
    end

    // Result registers: valid only in the DONE cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdData  <= '0;
            r_rdValid <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_rdValid <= w_complete & ~r_memReqWr & ~bus.memErr;
            r_err     <= w_unal_err | w_expire | (w_complete & bus.memErr);
            if (w_complete && !r_memReqWr) begin
                r_rdData <= bus.memRdData;
            end
        end
    end

    // One dump per halt assertion: remember that this assertion was served
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_halt_served <= 1'b0;
        end else if (!bus.halt) begin
            r_halt_served <= 1'b0;
        end else if (w_dump) begin
            r_halt_served <= 1'b1;
        end
    end

    assign bus.memReq    = r_memReq;
    assign bus.memReqWr  = r_memReqWr;
    assign bus.memAddr   = r_memAddr;
    assign bus.memWrData = r_memWrData;
    assign bus.memDump   = w_dump;
    assign bus.memStall  = w_stall;
    assign bus.rdData    = r_rdData;
    assign bus.rdValid   = r_rdValid;
    assign bus.err       = r_err;

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// Directed and random bench for dmem_stall_ctrl against a transaction-level model.
module tb_dmem_stall_ctrl;
    localparam int unsigned TIMEOUT = 15;
    localparam int unsigned CNT_W   = 4;

    logic clk = 1'b0;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    // Architectural model state
    logic [15:0] rd_model;
    logic [15:0] lat_addr;
    logic [15:0] lat_wdata;
    logic        lat_wr;
    logic        halt_lvl;
    logic        dump_owed;

    dmem_stall_ctrl_if bus();

    dmem_stall_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Drive halt for this cycle; a fresh rising level owes exactly one dump
    task automatic apply_halt();
        if (halt_lvl && !bus.halt) dump_owed = 1'b1;
        if (!halt_lvl) dump_owed = 1'b0;
        bus.halt = halt_lvl;
    endtask

    task automatic check_common(input bit may_dump);
        logic exp_dump;
        exp_dump = may_dump && halt_lvl && dump_owed;
        chk("memDump", 16'(bus.memDump), 16'(exp_dump));
        if (exp_dump) dump_owed = 1'b0;
        chk("rdData", bus.rdData, rd_model);
        chk("memAddr", bus.memAddr, lat_addr);
        chk("memWrData", bus.memWrData, lat_wdata);
        chk("memReqWr", 16'(bus.memReqWr), 16'(lat_wr));
    endtask

    // Cycle with no memory instruction; stray memDone must be ignored
    task automatic idle_cycle();
        @(negedge clk);
        apply_halt();
        bus.memEn     = 1'b0;
        bus.memWrt    = 1'($urandom);
        bus.addr      = 16'($urandom);
        bus.wrData    = 16'($urandom);
        bus.hazStall  = 1'($urandom);
        bus.memDone   = 1'($urandom);
        bus.memRdData = 16'($urandom);
        bus.memErr    = 1'($urandom);
        #1;
        chk("idle_memStall", 16'(bus.memStall), 16'd0);
        chk("idle_memReq", 16'(bus.memReq), 16'd0);
        chk("idle_rdValid", 16'(bus.rdValid), 16'd0);
        chk("idle_err", 16'(bus.err), 16'd0);
        check_common(1'b1);
    endtask

    // Instruction present but held by the hazard unit
    task automatic haz_cycle();
        @(negedge clk);
        apply_halt();
        bus.memEn    = 1'b1;
        bus.memWrt   = 1'b0;
        bus.addr     = 16'h0044;
        bus.hazStall = 1'b1;
        bus.memDone  = 1'b0;
        #1;
        chk("haz_memStall", 16'(bus.memStall), 16'd0);
        chk("haz_memReq", 16'(bus.memReq), 16'd0);
        chk("haz_err", 16'(bus.err), 16'd0);
        check_common(1'b1);
    endtask

    // One instruction from start cycle through DONE; lat<0 means memory never answers
    task automatic access(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                          input int lat, input logic [15:0] rdat, input logic merr);
        bit   unal;
        int   n_stall;
        logic exp_err;
        unal = a[0];
        if (unal)         n_stall = 1;
        else if (lat < 0) n_stall = 1 + int'(TIMEOUT);
        else              n_stall = lat + 2;
        exp_err = unal || (lat < 0) || merr;
        for (int c = 0; c <= n_stall; c++) begin
            @(negedge clk);
            apply_halt();
            bus.memEn    = 1'b1;
            bus.memWrt   = wr;
            bus.addr     = a;
            bus.wrData   = wd;
            bus.hazStall = 1'b0;
            if (!unal && c >= 1 && c < n_stall) begin
                bus.memDone   = (lat >= 0) && (c == lat + 1);
                bus.memRdData = bus.memDone ? rdat : 16'($urandom);
                bus.memErr    = bus.memDone ? merr : 1'($urandom);
            end else begin
                bus.memDone   = 1'($urandom);
                bus.memRdData = 16'($urandom);
                bus.memErr    = 1'($urandom);
            end
            if (c == n_stall && !unal && lat >= 0 && !wr) rd_model = rdat;
            #1;
            chk("memStall", 16'(bus.memStall), 16'(c < n_stall));
            chk("memReq", 16'(bus.memReq), 16'(!unal && c == 1));
            chk("rdValid", 16'(bus.rdValid), 16'(c == n_stall && !wr && !exp_err));
            chk("err", 16'(bus.err), 16'(c == n_stall && exp_err));
            check_common(1'b0);
            if (c == 0 && !unal) begin
                lat_addr  = a;
                lat_wdata = wd;
                lat_wr    = wr;
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.memEn     = 1'b1;
        bus.memWrt    = 1'b0;
        bus.addr      = 16'h0010;
        bus.wrData    = 16'h0000;
        bus.hazStall  = 1'b0;
        bus.halt      = 1'b1;
        bus.memDone   = 1'b0;
        bus.memRdData = 16'h0000;
        bus.memErr    = 1'b0;
        rd_model      = 16'h0000;
        lat_addr      = 16'h0000;
        lat_wdata     = 16'h0000;
        lat_wr        = 1'b0;
        halt_lvl      = 1'b0;
        dump_owed     = 1'b0;

        // Reset state, with memEn and halt high to exercise output gating
        @(negedge clk);
        #1;
        chk("rst_memStall", 16'(bus.memStall), 16'd0);
        chk("rst_memDump", 16'(bus.memDump), 16'd0);
        chk("rst_memReq", 16'(bus.memReq), 16'd0);
        chk("rst_memReqWr", 16'(bus.memReqWr), 16'd0);
        chk("rst_memAddr", bus.memAddr, 16'h0000);
        chk("rst_memWrData", bus.memWrData, 16'h0000);
        chk("rst_rdData", bus.rdData, 16'h0000);
        chk("rst_rdValid", 16'(bus.rdValid), 16'd0);
        chk("rst_err", 16'(bus.err), 16'd0);
        @(negedge clk);
        bus.halt  = 1'b0;
        bus.memEn = 1'b0;
        rst       = 1'b0;
        idle_cycle();
        idle_cycle();

        // Aligned load, latency 3
        access(1'b0, 16'h0010, 16'h0000, 3, 16'hBEEF, 1'b0);
        idle_cycle();
        // Store, latency 0
        access(1'b1, 16'h0020, 16'h1234, 0, 16'h5555, 1'b0);
        idle_cycle();
        idle_cycle();
        // Unaligned load
        access(1'b0, 16'h0011, 16'h0000, 0, 16'hDEAD, 1'b0);
        idle_cycle();
        // Timeout: memory never answers
        access(1'b0, 16'h0030, 16'h0000, -1, 16'h0000, 1'b0);
        idle_cycle();
        // memDone with memErr in the same cycle the timeout is reached
        access(1'b0, 16'h0032, 16'h0000, int'(TIMEOUT) - 1, 16'hA5A5, 1'b1);
        // Hazard hold, then release straight into the request (back-to-back)
        repeat (3) haz_cycle();
        access(1'b0, 16'h0044, 16'h0000, 1, 16'h0F0F, 1'b0);
        access(1'b1, 16'h0046, 16'hCAFE, 2, 16'h0000, 1'b0);

        // Reset in the 2nd BUSY cycle, then a late memDone
        @(negedge clk);
        apply_halt();
        bus.memEn    = 1'b1;
        bus.memWrt   = 1'b0;
        bus.addr     = 16'h0040;
        bus.hazStall = 1'b0;
        bus.memDone  = 1'b0;
        #1;
        chk("ab_start_stall", 16'(bus.memStall), 16'd1);
        @(negedge clk);
        #1;
        chk("ab_busy1_req", 16'(bus.memReq), 16'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        rd_model  = 16'h0000;
        lat_addr  = 16'h0000;
        lat_wdata = 16'h0000;
        lat_wr    = 1'b0;
        chk("ab_memStall", 16'(bus.memStall), 16'd0);
        chk("ab_memReq", 16'(bus.memReq), 16'd0);
        chk("ab_rdValid", 16'(bus.rdValid), 16'd0);
        chk("ab_err", 16'(bus.err), 16'd0);
        check_common(1'b0);
        @(negedge clk);
        rst           = 1'b0;
        bus.memEn     = 1'b0;
        bus.memDone   = 1'b1;
        bus.memRdData = 16'hFFFF;
        #1;
        chk("late_rdValid", 16'(bus.rdValid), 16'd0);
        chk("late_err", 16'(bus.err), 16'd0);
        chk("late_memStall", 16'(bus.memStall), 16'd0);
        idle_cycle();
        idle_cycle();

        // Halt raised while an access is in flight: one dump once back in IDLE
        halt_lvl = 1'b1;
        access(1'b0, 16'h0050, 16'h0000, 4, 16'h7777, 1'b0);
        idle_cycle();
        idle_cycle();
        halt_lvl = 1'b0;
        idle_cycle();
        halt_lvl = 1'b1;
        idle_cycle();
        idle_cycle();
        halt_lvl = 1'b0;
        idle_cycle();

        // Random traffic
        repeat (60) begin : rnd_blk
            int          lat;
            logic [15:0] a;
            a = 16'($urandom);
            if ($urandom_range(3) != 0) a[0] = 1'b0;
            lat = ($urandom_range(7) == 0) ? -1 : int'($urandom_range(TIMEOUT - 1));
            halt_lvl = ($urandom_range(3) == 0);
            access(1'($urandom), a, 16'($urandom), lat, 16'($urandom), ($urandom_range(4) == 0));
            repeat ($urandom_range(2)) idle_cycle();
        end
        halt_lvl = 1'b0;
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
